// File: rtl/guess_input_pkg.sv
// Shared game constants and the guess-entry FSM state type.
package guess_input_pkg;

  localparam int N_HOLES = 8;
  localparam int GUESS_W = 3;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    ACCEPT       = 2'd1,
    WAIT_RELEASE = 2'd2
  } state_t;

endpackage

// File: rtl/guess_input_button_debounce.sv
// One hole button: SYNC_STAGES-deep synchronizer followed by a consecutive-cycle
// debounce counter that flips the clean level once the input has held long enough.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_clean
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_clean;
  logic                   w_synced;
  logic                   w_differs;

  assign w_synced  = r_sync[SYNC_STAGES-1];
  assign w_differs = (w_synced != r_clean);

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of its neighbours regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync  <= '0;
      r_cnt   <= '0;
      r_clean <= 1'b0;
    end else begin
      r_sync[0] <= i_btn;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
      // The count restarts on any return to the clean level and stops at the
      // accept point, so it can never wrap.
      if (!w_differs) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_clean <= w_synced;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_clean = r_clean;

endmodule

// File: rtl/guess_input.sv
// Hole-button front end: debounces all holes, then turns a single clean press
// into one guess strobe and flags simultaneous presses.
module guess_input
  import guess_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_HOLES-1:0] btn,
  output logic [GUESS_W-1:0] user_guess,
  output logic               eval_now,
  output logic               multi_press,
  output logic [N_HOLES-1:0] btn_clean
);

  logic [N_HOLES-1:0] w_clean;
  logic               w_any;
  logic               w_onehot;
  logic [GUESS_W-1:0] w_index;

  state_t             r_state;
  state_t             w_next_state;
  logic [GUESS_W-1:0] r_guess;
  logic [GUESS_W-1:0] w_next_guess;
  logic               r_eval;
  logic               w_next_eval;
  logic               r_multi;
  logic               w_next_multi;

  for (genvar g = 0; g < N_HOLES; g++) begin : g_hole
    button_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .SYNC_STAGES     (SYNC_STAGES)
    ) u_debounce (
      .clk     (clk),
      .rst     (rst),
      .i_btn   (btn[g]),
      .o_clean (w_clean[g])
    );
  end

  assign w_any    = |w_clean;
  assign w_onehot = w_any && ((w_clean & (w_clean - 1'b1)) == '0);

  // NOTE: every signal written in a combinational block gets a default first,
  // otherwise an unassigned path would infer a latch.
  always_comb begin
    w_index = '0;
    for (int i = 0; i < N_HOLES; i++) begin
      if (w_clean[i]) w_index = GUESS_W'(i);
    end
  end

  // Strobes are computed one state ahead and registered, so eval_now is high
  // exactly while the FSM sits in ACCEPT.
  always_comb begin
    w_next_state = r_state;
    w_next_guess = r_guess;
    w_next_eval  = 1'b0;
    w_next_multi = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_onehot) begin
          w_next_state = ACCEPT;
          w_next_guess = w_index;
          w_next_eval  = 1'b1;
        end else if (w_any) begin
          w_next_state = WAIT_RELEASE;
          w_next_multi = 1'b1;
        end
      end
      ACCEPT: begin
        w_next_state = WAIT_RELEASE;
      end
      WAIT_RELEASE: begin
        if (!w_any) w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_guess <= '0;
      r_eval  <= 1'b0;
      r_multi <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_guess <= w_next_guess;
      r_eval  <= w_next_eval;
      r_multi <= w_next_multi;
    end
  end

  assign user_guess  = r_guess;
  assign eval_now    = r_eval;
  assign multi_press = r_multi;
  assign btn_clean   = w_clean;

endmodule

// File: tb/tb_guess_input.sv
// Self-checking bench for guess_input: directed scenarios plus random button
// traffic, all compared every cycle against a window-based reference model.
module tb_guess_input;

  localparam int D = 4;
  localparam int S = 2;

  logic       clk;
  logic       rst;
  logic [7:0] btn;
  logic [2:0] user_guess;
  logic       eval_now;
  logic       multi_press;
  logic [7:0] btn_clean;

  guess_input #(
    .DEBOUNCE_CYCLES (D),
    .SYNC_STAGES     (S)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn         (btn),
    .user_guess  (user_guess),
    .eval_now    (eval_now),
    .multi_press (multi_press),
    .btn_clean   (btn_clean)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  logic [7:0] hist[$];
  logic [7:0] m_clean;
  logic [2:0] m_guess;
  logic       m_eval;
  logic       m_multi;
  bit         m_armed;
  bit         m_just_accepted;

  // Per-scenario observations
  int cyc;
  int n_eval;
  int n_multi;
  int last_eval_cyc;
  int first_clean_cyc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Raw level seen by the debounce counter at the k-th edge after reset.
  function automatic logic [7:0] sample(input int k);
    if (k - S >= 1) return hist[k-S-1];
    return 8'h00;
  endfunction

  task automatic model_edge(input logic [7:0] b, input logic r);
    int k;
    bit all_differ;
    if (r) begin
      hist.delete();
      m_clean = '0; m_guess = '0; m_eval = 1'b0; m_multi = 1'b0;
      m_armed = 1'b1; m_just_accepted = 1'b0;
      return;
    end
    hist.push_back(b);
    k = hist.size();
    m_eval  = 1'b0;
    m_multi = 1'b0;
    if (m_just_accepted) begin
      m_just_accepted = 1'b0;
    end else if (m_armed) begin
      if ($countones(m_clean) == 1) begin
        m_eval = 1'b1;
        for (int i = 0; i < 8; i++) if (m_clean[i]) m_guess = 3'(i);
        m_armed = 1'b0;
        m_just_accepted = 1'b1;
      end else if ($countones(m_clean) > 1) begin
        m_multi = 1'b1;
        m_armed = 1'b0;
      end
    end else if (m_clean == 8'h00) begin
      m_armed = 1'b1;
    end
    // A bit flips once its last D samples all disagree with the clean level.
    if (k >= D) begin
      for (int i = 0; i < 8; i++) begin
        all_differ = 1'b1;
        for (int j = k - D + 1; j <= k; j++) begin
          logic [7:0] s;
          s = sample(j);
          if (s[i] == m_clean[i]) all_differ = 1'b0;
        end
        if (all_differ) m_clean[i] = ~m_clean[i];
      end
    end
  endtask

  task automatic tick(input logic [7:0] b, input logic r);
    @(negedge clk);
    btn = b;
    rst = r;
    @(posedge clk);
    model_edge(b, r);
    #1;
    check("btn_clean", 32'(btn_clean), 32'(m_clean));
    check("user_guess", 32'(user_guess), 32'(m_guess));
    check("eval_now", 32'(eval_now), 32'(m_eval));
    check("multi_press", 32'(multi_press), 32'(m_multi));
    cyc++;
    if (eval_now === 1'b1) begin
      n_eval++;
      last_eval_cyc = cyc;
    end
    if (multi_press === 1'b1) n_multi++;
    if (first_clean_cyc < 0 && btn_clean !== 8'h00) first_clean_cyc = cyc;
  endtask

  task automatic clear_stats();
    cyc = 0; n_eval = 0; n_multi = 0; last_eval_cyc = -1; first_clean_cyc = -1;
  endtask

  task automatic do_reset();
    tick(8'h00, 1'b1);
    clear_stats();
  endtask

  task automatic hold(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) tick(b, 1'b0);
  endtask

  initial begin
    btn = 8'h00;
    rst = 1'b1;
    clear_stats();

    // Reset state
    tick(8'h00, 1'b1);
    tick(8'h00, 1'b1);
    check("reset_clean", 32'(btn_clean), 32'h0);
    check("reset_guess", 32'(user_guess), 32'h0);

    // Clean press on hole 5
    do_reset();
    hold(8'h20, 20);
    check("press_clean_cycle", 32'(first_clean_cyc), 32'd6);
    check("press_eval_cycle", 32'(last_eval_cyc), 32'd7);
    check("press_eval_count", 32'(n_eval), 32'd1);
    check("press_guess", 32'(user_guess), 32'd5);
    check("press_multi_count", 32'(n_multi), 32'd0);
    hold(8'h00, 12);

    // Bounce on hole 2: final press starts on cycle 5
    do_reset();
    tick(8'h04, 1'b0); tick(8'h00, 1'b0); tick(8'h04, 1'b0); tick(8'h00, 1'b0);
    hold(8'h04, 20);
    check("bounce_eval_count", 32'(n_eval), 32'd1);
    check("bounce_eval_cycle", 32'(last_eval_cyc), 32'd11);
    check("bounce_guess", 32'(user_guess), 32'd2);
    hold(8'h00, 12);

    // Two buttons at once, user_guess keeps 2
    clear_stats();
    hold(8'h81, 15);
    check("multi_count", 32'(n_multi), 32'd1);
    check("multi_eval_count", 32'(n_eval), 32'd0);
    check("multi_guess_kept", 32'(user_guess), 32'd2);
    hold(8'h00, 12);
    clear_stats();
    hold(8'h02, 15);
    check("after_multi_eval", 32'(n_eval), 32'd1);
    check("after_multi_guess", 32'(user_guess), 32'd1);
    hold(8'h00, 12);

    // Hold hole 0, add hole 1 while waiting
    clear_stats();
    hold(8'h01, 10);
    hold(8'h03, 15);
    check("add_eval_count", 32'(n_eval), 32'd1);
    check("add_multi_count", 32'(n_multi), 32'd0);
    check("add_guess", 32'(user_guess), 32'd0);
    hold(8'h00, 12);
    clear_stats();
    hold(8'h08, 15);
    check("add_next_guess", 32'(user_guess), 32'd3);
    check("add_next_eval", 32'(n_eval), 32'd1);
    hold(8'h00, 12);

    // Reset while hole 4 is held; re-debounce from zero afterwards
    do_reset();
    hold(8'h10, 10);
    check("hold_guess", 32'(user_guess), 32'd4);
    tick(8'h10, 1'b1);
    check("midhold_rst_clean", 32'(btn_clean), 32'h0);
    check("midhold_rst_guess", 32'(user_guess), 32'h0);
    check("midhold_rst_eval", 32'(eval_now), 32'h0);
    clear_stats();
    hold(8'h10, 12);
    check("post_rst_eval_count", 32'(n_eval), 32'd1);
    check("post_rst_eval_cycle", 32'(last_eval_cyc), 32'd7);
    check("post_rst_guess", 32'(user_guess), 32'd4);
    hold(8'h00, 12);

    // Short glitch on hole 7
    clear_stats();
    hold(8'h80, 3);
    hold(8'h00, 15);
    check("glitch_clean", 32'(first_clean_cyc), 32'hffff_ffff);
    check("glitch_eval", 32'(n_eval), 32'd0);
    check("glitch_multi", 32'(n_multi), 32'd0);

    // Random traffic against the model
    for (int seg = 0; seg < 300; seg++) begin
      int kind;
      int len;
      logic [7:0] pat;
      kind = $urandom_range(0, 19);
      len  = $urandom_range(1, 12);
      if (kind <= 10) begin
        pat = 8'h01 << $urandom_range(0, 7);
        hold(pat, len);
      end else if (kind <= 13) begin
        pat = 8'($urandom) | (8'h01 << $urandom_range(0, 3)) | (8'h10 << $urandom_range(0, 3));
        hold(pat, len);
      end else if (kind <= 16) begin
        hold(8'h00, len);
      end else if (kind <= 18) begin
        for (int i = 0; i < len; i++) tick(8'($urandom), 1'b0);
      end else begin
        tick(8'h01 << $urandom_range(0, 7), 1'b1);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/guess_input.md
GUESS_INPUT -- requirements
Module: guess_input

Interface
- REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 500000, meaning the number of consecutive clk cycles a synchronized button level must hold before it is accepted.
- REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, meaning the flip-flop depth of the input synchronizer per button.
- REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock.
- REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
- REQ-005 The block SHALL have port btn, input, 8 bits: raw asynchronous hole buttons, bit i = hole i, 1 = pressed.
- REQ-006 The block SHALL have port user_guess, output, 3 bits: encoded index of the last accepted hole, feeding the game core.
- REQ-007 The block SHALL have port eval_now, output, 1 bit: single-cycle strobe, asserted when user_guess holds a new guess.
- REQ-008 The block SHALL have port multi_press, output, 1 bit: single-cycle strobe marking a rejected simultaneous press.
- REQ-009 The block SHALL have port btn_clean, output, 8 bits: debounced button levels, for display and debug.

Function
- REQ-010 Each btn bit SHALL pass through SYNC_STAGES flops before debounce.
- REQ-011 Each btn_clean bit SHALL change only after its synchronized input differs from btn_clean for DEBOUNCE_CYCLES consecutive cycles.
  - Any intermediate return to the current level SHALL restart that bit's counter from 0.
- REQ-012 The debounce counter width SHALL be clog2(DEBOUNCE_CYCLES+1).
  - The counter SHALL saturate and never wrap.
- REQ-013 Latency SHALL be fixed: a clean raw edge reaches btn_clean after SYNC_STAGES+DEBOUNCE_CYCLES cycles.
  - eval_now SHALL assert exactly 1 cycle after that btn_clean change.
- REQ-014 The FSM SHALL have three states: IDLE, ACCEPT and WAIT_RELEASE.
- REQ-015 In IDLE with btn_clean == 0, the FSM SHALL stay in IDLE.
- REQ-016 In IDLE with exactly one btn_clean bit set, the FSM SHALL go to ACCEPT.
  - user_guess SHALL load that bit index.
- REQ-017 In IDLE with two or more btn_clean bits set, the FSM SHALL go to WAIT_RELEASE.
  - multi_press SHALL pulse for 1 cycle.
  - user_guess SHALL stay unchanged and eval_now SHALL not assert.
- REQ-018 In ACCEPT, eval_now SHALL be 1 for exactly one cycle.
  - The FSM SHALL then go to WAIT_RELEASE unconditionally.
- REQ-019 In WAIT_RELEASE, the FSM SHALL return to IDLE only when btn_clean == 0.
  - Extra buttons pressed while waiting SHALL produce no eval_now and no multi_press.
- REQ-020 A press held indefinitely SHALL produce exactly one eval_now.
- REQ-021 user_guess SHALL hold its value between strobes.
  - It SHALL be stable on the eval_now cycle and all later cycles until the next ACCEPT.
- REQ-022 eval_now and multi_press SHALL never assert in the same cycle.
- REQ-023 All outputs SHALL be registered, with no combinational path from btn to any output.

Reset
- REQ-024 On rst=1 at a clk edge, the block SHALL set:
  - FSM to IDLE;
  - user_guess, eval_now, multi_press and btn_clean to 0;
  - all synchronizer flops and debounce counters to 0.
- REQ-025 Reset asserted mid-debounce or mid-hold SHALL discard the pending state.
  - A button still held after reset release SHALL be re-debounced from 0.
  - It SHALL then yield one eval_now, because btn_clean rises from 0.
- REQ-026 Reset SHALL take priority over every other event in the same cycle.

Structure
- REQ-027 The shared game package SHALL hold:
  - N_HOLES = 8;
  - GUESS_W = 3;
  - the FSM state type, with IDLE, ACCEPT and WAIT_RELEASE encodings.
- REQ-028 One sub-module, button_debounce, SHALL implement synchronizer, counter and clean level for 1 bit.
  - It SHALL take parameters DEBOUNCE_CYCLES and SYNC_STAGES.
  - guess_input SHALL instantiate it N_HOLES times.
- REQ-029 The one-hot test and index encoding SHALL live in guess_input.

Verification (DEBOUNCE_CYCLES=4, SYNC_STAGES=2)
- REQ-030 Clean press: btn=8'h20 held 20 cycles -> btn_clean[5] rises at cycle 6, eval_now=1 at cycle 7 only, user_guess=5.
- REQ-031 Bounce: btn[2] toggles 1,0,1,0 each cycle, then holds 1 -> exactly one eval_now, arriving 7 cycles after the last toggle, with user_guess=2.
- REQ-032 Two buttons: btn=8'h81 -> multi_press pulses once, eval_now stays 0, user_guess keeps its prior value. After release, btn=8'h02 -> eval_now, user_guess=1.
- REQ-033 Hold and add: btn=8'h01, then 8'h03 while held -> one eval_now with user_guess=0 and no multi_press. Full release then btn=8'h08 -> user_guess=3.
- REQ-034 Reset mid-hold: btn=8'h10 accepted, rst pulsed 1 cycle while held -> all outputs 0. Then eval_now again with user_guess=4, 6 cycles after rst deasserts.
- REQ-035 Glitch: btn[7] high for 3 cycles, then low -> btn_clean stays 0 and no strobes occur.
